// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, line levels and parity helper for the UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    // Narrower words are zero-extended by the caller; zeros do not change the XOR
    function automatic logic uart_parity(input logic [8:0] data, input logic odd);
        return ^data ^ odd;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider emitting a one-cycle tick at the end of each serial bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == CW'(CLKS_PER_BIT - 1));
    // Count cycles within a bit; reload at every boundary and on frame start
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, DATA_W bits LSB first, optional parity, 1-2 stops)
// Define UART_TX_PARITY_EN to add the parity bit selected by parity_odd.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_odd,
    output logic              tx,
    output logic              busy
);
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    uart_tx_state_t    r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IW-1:0]     r_idx;
    logic              r_tx;
    logic              r_busy;
    logic              w_accept;
    logic              w_tick;

`ifdef UART_TX_PARITY_EN
    logic r_pbit;
`else
    logic w_unused_parity;
    assign w_unused_parity = parity_odd;
`endif

    assign tx_ready = (r_state == IDLE) && rst_n;
    assign w_accept = tx_valid && tx_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state != IDLE),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    // Frame sequencer: walks start, data, parity and stop bits, one per tick, with registered line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= UART_IDLE_LVL;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pbit  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= UART_IDLE_LVL;
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_state <= START;
                        r_shift <= tx_data;
                        r_idx   <= '0;
                        r_tx    <= UART_START_LVL;
                        r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_pbit  <= uart_parity(9'(tx_data), parity_odd);
`endif
                    end
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_tx    <= r_shift[0];
                    r_idx   <= '0;
                end
                DATA: if (w_tick) begin
                    if (r_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
                        r_tx    <= r_pbit;
`else
                        r_state <= STOP;
                        r_tx    <= UART_IDLE_LVL;
`endif
                        r_idx   <= '0;
                    end else begin
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                        r_idx   <= r_idx + IW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_tx    <= UART_IDLE_LVL;
                    r_idx   <= '0;
                end
`endif
                STOP: if (w_tick) begin
                    if (r_idx == LAST_STOP) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LVL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame across four parameter sets
module tb_uart_tx_frame;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       odd_r;
    logic       valid_r [4];
    logic [8:0] data_r  [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       ready_w [4];
    int         tests;
    int         fails;

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[0]), .tx_ready(ready_w[0]),
        .tx_data(data_r[0][7:0]), .parity_odd(odd_r), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[1]), .tx_ready(ready_w[1]),
        .tx_data(data_r[1][7:0]), .parity_odd(odd_r), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[2]), .tx_ready(ready_w[2]),
        .tx_data(data_r[2][4:0]), .parity_odd(odd_r), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx_frame #(.DATA_W(9), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[3]), .tx_ready(ready_w[3]),
        .tx_data(data_r[3]), .parity_odd(odd_r), .tx(tx_w[3]), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and return in the first cycle after the accepting edge
    task automatic start(input int sel, input logic [8:0] d, input logic odd, input bit keep,
                         output int waited);
        int n;
        n = 0;
        data_r[sel]  = d;
        odd_r        = odd;
        valid_r[sel] = 1'b1;
        while (!ready_w[sel] && n < 100) begin
            step();
            n++;
        end
        chk($sformatf("accept_timeout_%0d", sel), 9'(n >= 100), 9'd0);
        step();
        if (!keep) valid_r[sel] = 1'b0;
        waited = n;
    endtask

    // Check every cycle of a frame, then the first idle cycle after it
    task automatic check_frame(input int sel, input logic [8:0] d, input int dw, input int cpb,
                               input int stops, input logic pexp, input int chg_at,
                               input logic [8:0] chg_val, input string tag);
        int   nb;
        logic eb;
        nb = 1 + dw + P + stops;
        for (int b = 0; b < nb; b++) begin
            eb = (b == 0) ? 1'b0 : (b <= dw) ? d[b-1] : (P == 1 && b == dw + 1) ? pexp : 1'b1;
            for (int c = 0; c < cpb; c++) begin
                chk($sformatf("%s_b%0d_c%0d_tx", tag, b, c), 9'(tx_w[sel]), 9'(eb));
                chk($sformatf("%s_b%0d_c%0d_busy", tag, b, c), 9'(busy_w[sel]), 9'd1);
                chk($sformatf("%s_b%0d_c%0d_ready", tag, b, c), 9'(ready_w[sel]), 9'd0);
                if (b * cpb + c == chg_at) data_r[sel] = chg_val;
                step();
            end
        end
        chk({tag, "_end_ready"}, 9'(ready_w[sel]), 9'd1);
        chk({tag, "_end_busy"}, 9'(busy_w[sel]), 9'd0);
        chk({tag, "_end_tx"}, 9'(tx_w[sel]), 9'd1);
    endtask

    initial begin
        int w;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        odd_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_r[i] = 1'b0;
            data_r[i]  = '0;
        end
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx_%0d", i), 9'(tx_w[i]), 9'd1);
            chk($sformatf("rst_busy_%0d", i), 9'(busy_w[i]), 9'd0);
            chk($sformatf("rst_ready_%0d", i), 9'(ready_w[i]), 9'd0);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 9'(ready_w[0]), 9'd1);

        start(0, 9'h0A5, 1'b0, 1'b0, w);
        check_frame(0, 9'h0A5, 8, 4, 1, 1'b0, -1, 9'h0, "basic");

        start(0, 9'h007, 1'b0, 1'b0, w);
        check_frame(0, 9'h007, 8, 4, 1, 1'b1, -1, 9'h0, "par_even");
        start(0, 9'h007, 1'b1, 1'b0, w);
        check_frame(0, 9'h007, 8, 4, 1, 1'b0, -1, 9'h0, "par_odd");

        start(1, 9'h000, 1'b0, 1'b1, w);
        check_frame(1, 9'h000, 8, 4, 2, 1'b0, 10, 9'h0FF, "b2b1");
        start(1, 9'h0FF, 1'b0, 1'b0, w);
        chk("b2b_gap_wait", 9'(w), 9'd0);
        check_frame(1, 9'h0FF, 8, 4, 2, 1'b0, -1, 9'h0, "b2b2");

        start(0, 9'h0C3, 1'b0, 1'b0, w);
        repeat (17) step();
        chk("abort_bit3_tx", 9'(tx_w[0]), 9'd0);
        rst_n = 1'b0;
        step();
        chk("abort_tx", 9'(tx_w[0]), 9'd1);
        chk("abort_busy", 9'(busy_w[0]), 9'd0);
        chk("abort_ready", 9'(ready_w[0]), 9'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_rel", 9'(ready_w[0]), 9'd1);
        step();
        chk("abort_idle_tx", 9'(tx_w[0]), 9'd1);
        start(0, 9'h03C, 1'b0, 1'b0, w);
        check_frame(0, 9'h03C, 8, 4, 1, 1'b0, -1, 9'h0, "after_abort");

        start(2, 9'h01F, 1'b0, 1'b0, w);
        check_frame(2, 9'h01F, 5, 2, 1, 1'b1, -1, 9'h0, "w5");
        start(3, 9'h1AA, 1'b0, 1'b0, w);
        check_frame(3, 9'h1AA, 9, 2, 1, 1'b1, -1, 9'h0, "w9");

        for (int i = 0; i < 1000; i++) begin
            chk("idle_tx", 9'(tx_w[0]), 9'd1);
            chk("idle_busy", 9'(busy_w[0]), 9'd0);
            chk("idle_ready", 9'(ready_w[0]), 9'd1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
